// File: rtl/gemv_stream_array.sv
// Streaming GeMV engine: one COLS-wide chunk plus its ROWS x COLS weight tile per beat,
// saturating accumulation across a job, result held in a one-slot valid/ready buffer.
module gemv_stream_array #(
   parameter int ROWS         = 32,
   parameter int COLS         = 8,
   parameter int INPUT_WIDTH  = 8,
   parameter int WEIGHT_WIDTH = 8,
   parameter int ACC_WIDTH    = 32,
   parameter int MAX_TILES    = 16,
   parameter int TW           = $clog2(MAX_TILES + 1)
) (
   input  logic                                 clk,
   input  logic                                 rst_n,
   input  logic                                 sw_clear,
   input  logic                                 cfg_signed,
   input  logic [TW-1:0]                        cfg_num_tiles,
   input  logic                                 in_valid,
   output logic                                 in_ready,
   input  logic [COLS*INPUT_WIDTH-1:0]          in_vector,
   input  logic [ROWS*COLS*WEIGHT_WIDTH-1:0]    in_weights,
   output logic                                 out_valid,
   input  logic                                 out_ready,
   output logic [ROWS*ACC_WIDTH-1:0]            out_vector,
   output logic                                 out_sat,
   output logic                                 busy
);

   // Extended product, full-precision per-beat dot, and the pre-clamp sum widths.
   localparam int PW = INPUT_WIDTH + WEIGHT_WIDTH + 2;
   localparam int DW = PW + $clog2(COLS);
   localparam int SW = ((ACC_WIDTH > DW) ? ACC_WIDTH : DW) + 1;
   localparam logic signed [SW-1:0] ACC_MAX =
      {{(SW-ACC_WIDTH+1){1'b0}}, {(ACC_WIDTH-1){1'b1}}};
   localparam logic signed [SW-1:0] ACC_MIN = ~ACC_MAX;

   typedef enum logic {IDLE, ACCUM} state_e;

   state_e                        state_q, state_d;
   logic [TW-1:0]                 tcnt_q, tcnt_d;
   logic [TW-1:0]                 ntl_q, ntl_d;
   logic                          sgn_q, sgn_d;
   logic                          job_sat_q, job_sat_d;
   logic                          out_valid_q, out_valid_d;
   logic                          out_sat_q, out_sat_d;
   logic signed [ACC_WIDTH-1:0]   acc_q [ROWS];
   logic signed [ACC_WIDTH-1:0]   acc_d [ROWS];
   logic signed [ACC_WIDTH-1:0]   res_q [ROWS];
   logic signed [ACC_WIDTH-1:0]   res_d [ROWS];

   logic signed [ACC_WIDTH-1:0]   acc_sum [ROWS];
   logic signed [DW-1:0]          dot [ROWS];
   logic [ROWS-1:0]               row_sat;
   logic signed [INPUT_WIDTH:0]   xe;
   logic signed [WEIGHT_WIDTH:0]  we;
   logic signed [PW-1:0]          prod;
   logic signed [ACC_WIDTH-1:0]   base;
   logic signed [SW-1:0]          sum;
   logic [TW-1:0]                 nt_eff, nt_cur;
   logic                          first_beat, last_beat, acc_en, beat_sat, sgn_cur;

   // sw_clear forces in_ready high; the beat it meets is dropped anyway.
   assign in_ready   = sw_clear || !out_valid_q || out_ready;
   assign acc_en     = in_valid && in_ready && !sw_clear;
   assign first_beat = (state_q == IDLE);
   assign sgn_cur    = first_beat ? cfg_signed : sgn_q;
   assign nt_cur     = first_beat ? nt_eff : ntl_q;
   assign last_beat  = (tcnt_q == nt_cur - TW'(1));
   assign beat_sat   = |row_sat;

   assign out_valid  = out_valid_q;
   assign out_sat    = out_sat_q;
   assign busy       = (state_q == ACCUM);

   genvar g;
   generate
      for (g = 0; g < ROWS; g++) begin : g_out
         assign out_vector[g*ACC_WIDTH +: ACC_WIDTH] = res_q[g];
      end
   endgenerate

   always_comb begin
      if (cfg_num_tiles == '0) begin
         nt_eff = TW'(1);
      end else if (cfg_num_tiles > TW'(MAX_TILES)) begin
         nt_eff = TW'(MAX_TILES);
      end else begin
         nt_eff = cfg_num_tiles;
      end
   end

   // Per-row dot product, then base + dot clamped to the signed accumulator range.
   always_comb begin
      xe      = '0;
      we      = '0;
      prod    = '0;
      base    = '0;
      sum     = '0;
      row_sat = '0;
      for (int r = 0; r < ROWS; r++) begin
         dot[r] = '0;
         for (int c = 0; c < COLS; c++) begin
            xe = signed'({sgn_cur & in_vector[c*INPUT_WIDTH + INPUT_WIDTH - 1],
                          in_vector[c*INPUT_WIDTH +: INPUT_WIDTH]});
            we = signed'({sgn_cur & in_weights[(r*COLS + c)*WEIGHT_WIDTH + WEIGHT_WIDTH - 1],
                          in_weights[(r*COLS + c)*WEIGHT_WIDTH +: WEIGHT_WIDTH]});
            prod   = xe * we;
            dot[r] = dot[r] + DW'(prod);
         end
         base = first_beat ? '0 : acc_q[r];
         sum  = SW'(base) + SW'(dot[r]);
         if (sum > ACC_MAX) begin
            acc_sum[r] = ACC_MAX[ACC_WIDTH-1:0];
            row_sat[r] = 1'b1;
         end else if (sum < ACC_MIN) begin
            acc_sum[r] = ACC_MIN[ACC_WIDTH-1:0];
            row_sat[r] = 1'b1;
         end else begin
            acc_sum[r] = sum[ACC_WIDTH-1:0];
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      tcnt_d      = tcnt_q;
      ntl_d       = ntl_q;
      sgn_d       = sgn_q;
      job_sat_d   = job_sat_q;
      out_valid_d = out_valid_q;
      out_sat_d   = out_sat_q;
      acc_d       = acc_q;
      res_d       = res_q;
      if (sw_clear) begin
         state_d     = IDLE;
         tcnt_d      = '0;
         job_sat_d   = 1'b0;
         out_valid_d = 1'b0;
         out_sat_d   = 1'b0;
      end else begin
         if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
         end
         if (acc_en) begin
            acc_d     = acc_sum;
            job_sat_d = beat_sat | (first_beat ? 1'b0 : job_sat_q);
            if (first_beat) begin
               ntl_d = nt_eff;
               sgn_d = cfg_signed;
            end
            // A last beat refills the slot even in the cycle it drains.
            if (last_beat) begin
               res_d       = acc_sum;
               out_sat_d   = job_sat_d;
               out_valid_d = 1'b1;
               state_d     = IDLE;
               tcnt_d      = '0;
            end else begin
               state_d = ACCUM;
               tcnt_d  = tcnt_q + TW'(1);
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         tcnt_q      <= '0;
         ntl_q       <= '0;
         sgn_q       <= 1'b0;
         job_sat_q   <= 1'b0;
         out_valid_q <= 1'b0;
         out_sat_q   <= 1'b0;
         for (int r = 0; r < ROWS; r++) begin
            acc_q[r] <= '0;
            res_q[r] <= '0;
         end
      end else begin
         state_q     <= state_d;
         tcnt_q      <= tcnt_d;
         ntl_q       <= ntl_d;
         sgn_q       <= sgn_d;
         job_sat_q   <= job_sat_d;
         out_valid_q <= out_valid_d;
         out_sat_q   <= out_sat_d;
         acc_q       <= acc_d;
         res_q       <= res_d;
      end
   end

endmodule

// File: tb/tb_gemv_stream_array.sv
// Bench for gemv_stream_array: a 32-bit and a 20-bit accumulator instance share one stimulus
// stream and are checked against an integer model of the job arithmetic.
module tb_gemv_stream_array;
   localparam int ROWS = 32;
   localparam int COLS = 8;
   localparam int IW   = 8;
   localparam int WW   = 8;
   localparam int MT   = 16;
   localparam int TW   = 5;
   localparam int AW   = 32;
   localparam int AWS  = 20;

   logic                       clk = 1'b0;
   logic                       rst_n = 1'b0;
   logic                       sw_clear = 1'b0;
   logic                       cfg_signed = 1'b0;
   logic [TW-1:0]              cfg_num_tiles = '0;
   logic                       in_valid = 1'b0;
   logic                       out_ready = 1'b1;
   logic [COLS*IW-1:0]         in_vector = '0;
   logic [ROWS*COLS*WW-1:0]    in_weights = '0;
   logic                       in_ready, out_valid, out_sat, busy;
   logic [ROWS*AW-1:0]         out_vector;
   logic                       in_ready_s, out_valid_s, out_sat_s, busy_s;
   logic [ROWS*AWS-1:0]        out_vector_s;

   int vectors = 0;
   int miscompares = 0;
   int cyc = 0;

   logic [7:0]          x_arr [MT][COLS];
   logic [7:0]          w_arr [MT][ROWS][COLS];
   logic [ROWS*AW-1:0]  exp_v, hold_v;
   logic [ROWS*AWS-1:0] exp_vs;
   logic                exp_sat, exp_sat_s;

   gemv_stream_array #(.ROWS(ROWS), .COLS(COLS), .INPUT_WIDTH(IW), .WEIGHT_WIDTH(WW),
                       .ACC_WIDTH(AW), .MAX_TILES(MT)) u_dut (
      .clk(clk), .rst_n(rst_n), .sw_clear(sw_clear), .cfg_signed(cfg_signed),
      .cfg_num_tiles(cfg_num_tiles), .in_valid(in_valid), .in_ready(in_ready),
      .in_vector(in_vector), .in_weights(in_weights), .out_valid(out_valid),
      .out_ready(out_ready), .out_vector(out_vector), .out_sat(out_sat), .busy(busy));

   gemv_stream_array #(.ROWS(ROWS), .COLS(COLS), .INPUT_WIDTH(IW), .WEIGHT_WIDTH(WW),
                       .ACC_WIDTH(AWS), .MAX_TILES(MT)) u_dut_s (
      .clk(clk), .rst_n(rst_n), .sw_clear(sw_clear), .cfg_signed(cfg_signed),
      .cfg_num_tiles(cfg_num_tiles), .in_valid(in_valid), .in_ready(in_ready_s),
      .in_vector(in_vector), .in_weights(in_weights), .out_valid(out_valid_s),
      .out_ready(out_ready), .out_vector(out_vector_s), .out_sat(out_sat_s), .busy(busy_s));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #2000000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- reference model ----------------
   function automatic longint ext8(input logic [7:0] v, input bit sg);
      if (sg && v[7]) return longint'(v) - 256;
      return longint'(v);
   endfunction

   function automatic int eff_tiles(input int n);
      if (n == 0) return 1;
      if (n > MT) return MT;
      return n;
   endfunction

   task automatic model_job(input int nb, input bit sg);
      longint d, a32, a20, hi32, lo32, hi20, lo20;
      hi32 = (longint'(1) << (AW - 1)) - 1;   lo32 = -hi32 - 1;
      hi20 = (longint'(1) << (AWS - 1)) - 1;  lo20 = -hi20 - 1;
      exp_sat = 1'b0;
      exp_sat_s = 1'b0;
      for (int r = 0; r < ROWS; r++) begin
         a32 = 0;
         a20 = 0;
         for (int b = 0; b < nb; b++) begin
            d = 0;
            for (int c = 0; c < COLS; c++) d += ext8(x_arr[b][c], sg) * ext8(w_arr[b][r][c], sg);
            a32 += d;
            a20 += d;
            if (a32 > hi32) begin a32 = hi32; exp_sat = 1'b1; end
            else if (a32 < lo32) begin a32 = lo32; exp_sat = 1'b1; end
            if (a20 > hi20) begin a20 = hi20; exp_sat_s = 1'b1; end
            else if (a20 < lo20) begin a20 = lo20; exp_sat_s = 1'b1; end
         end
         exp_v[r*AW +: AW]    = a32[AW-1:0];
         exp_vs[r*AWS +: AWS] = a20[AWS-1:0];
      end
   endtask

   function automatic int first_bad32(input logic [ROWS*AW-1:0] a, input logic [ROWS*AW-1:0] b);
      for (int r = 0; r < ROWS; r++) if (a[r*AW +: AW] !== b[r*AW +: AW]) return r;
      return 0;
   endfunction

   function automatic int first_bad20(input logic [ROWS*AWS-1:0] a, input logic [ROWS*AWS-1:0] b);
      for (int r = 0; r < ROWS; r++) if (a[r*AWS +: AWS] !== b[r*AWS +: AWS]) return r;
      return 0;
   endfunction

   // ---------------- drivers ----------------
   task automatic fill_random(input int nb);
      for (int b = 0; b < nb; b++) begin
         for (int c = 0; c < COLS; c++) x_arr[b][c] = 8'($urandom);
         for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) w_arr[b][r][c] = 8'($urandom);
      end
   endtask

   task automatic fill_const(input int nb, input logic [7:0] xv, input logic [7:0] wv);
      for (int b = 0; b < nb; b++) begin
         for (int c = 0; c < COLS; c++) x_arr[b][c] = xv;
         for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) w_arr[b][r][c] = wv;
      end
   endtask

   // Called at a negedge; returns at the negedge after the beat was taken.
   task automatic send_beat(input int b, input logic [TW-1:0] ntc, input logic sg);
      int waited;
      cfg_num_tiles = ntc;
      cfg_signed    = sg;
      for (int c = 0; c < COLS; c++) in_vector[c*IW +: IW] = x_arr[b][c];
      for (int r = 0; r < ROWS; r++)
         for (int c = 0; c < COLS; c++) in_weights[(r*COLS + c)*WW +: WW] = w_arr[b][r][c];
      in_valid = 1'b1;
      #1;
      waited = 0;
      while (!in_ready && waited < 50) begin
         @(negedge clk);
         #1;
         waited++;
      end
      if (waited >= 50) begin
         vectors++;
         miscompares++;
         $display("FAIL beat_accept_timeout beat %0d in_ready stayed %b want 1", b, in_ready);
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   // Later beats carry random cfg values, which the DUT must ignore.
   task automatic run_job(input int nb, input logic [TW-1:0] ntc, input logic sg);
      for (int b = 0; b < nb; b++) begin
         if (b == 0) send_beat(0, ntc, sg);
         else send_beat(b, TW'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
      vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
      vectors++; if (out_vector !== '0 || out_vector_s !== '0) begin miscompares++; $display("FAIL reset_out_vector got nonzero want 0"); end
      vectors++; if (out_sat !== 1'b0) begin miscompares++; $display("FAIL reset_out_sat got %b want 0", out_sat); end
      vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b want 0", busy); end
   endtask

   task automatic test_single_signed;
      int fb;
      for (int c = 0; c < COLS; c++) x_arr[0][c] = 8'd1;
      for (int r = 0; r < ROWS; r++)
         for (int c = 0; c < COLS; c++) w_arr[0][r][c] = 8'(r - 16);
      model_job(1, 1'b1);
      send_beat(0, TW'(1), 1'b1);
      in_valid = 1'b0;
      vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL single_valid got %b want 1", out_valid); end
      vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL single_busy got %b want 0", busy); end
      vectors++;
      if (out_vector !== exp_v) begin
         miscompares++; fb = first_bad32(out_vector, exp_v);
         $display("FAIL single_vec row %0d got %0d want %0d", fb, $signed(out_vector[fb*AW +: AW]), $signed(exp_v[fb*AW +: AW]));
      end
      vectors++; if (out_sat !== 1'b0) begin miscompares++; $display("FAIL single_sat got %b want 0", out_sat); end
      @(negedge clk);
   endtask

   task automatic test_four_unsigned;
      int fb, busy_cnt;
      fill_const(4, 8'd255, 8'd255);
      model_job(4, 1'b0);
      busy_cnt = 0;
      for (int b = 0; b < 4; b++) begin
         if (b == 0) send_beat(0, TW'(4), 1'b0);
         else send_beat(b, TW'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
         if (busy === 1'b1) busy_cnt++;
      end
      in_valid = 1'b0;
      vectors++; if (busy_cnt != 3) begin miscompares++; $display("FAIL four_busy_cycles got %0d want 3", busy_cnt); end
      vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL four_valid got %b want 1", out_valid); end
      vectors++;
      if (out_vector !== exp_v) begin
         miscompares++; fb = first_bad32(out_vector, exp_v);
         $display("FAIL four_vec row %0d got %0d want %0d", fb, $signed(out_vector[fb*AW +: AW]), $signed(exp_v[fb*AW +: AW]));
      end
      vectors++; if (out_sat !== exp_sat) begin miscompares++; $display("FAIL four_sat got %b want %b", out_sat, exp_sat); end
      vectors++;
      if (out_vector_s !== exp_vs) begin
         miscompares++; fb = first_bad20(out_vector_s, exp_vs);
         $display("FAIL four_vec20 row %0d got %0d want %0d", fb, $signed(out_vector_s[fb*AWS +: AWS]), $signed(exp_vs[fb*AWS +: AWS]));
      end
      vectors++; if (out_sat_s !== exp_sat_s) begin miscompares++; $display("FAIL four_sat20 got %b want %b", out_sat_s, exp_sat_s); end
      @(negedge clk);
   endtask

   task automatic test_saturation;
      int fb;
      for (int j = 0; j < 2; j++) begin
         if (j == 0) begin fill_const(4, 8'h80, 8'h80); model_job(4, 1'b1); run_job(4, TW'(4), 1'b1); end
         else begin fill_random(2); model_job(2, 1'b1); run_job(2, TW'(2), 1'b1); end
         in_valid = 1'b0;
         vectors++;
         if (out_vector_s !== exp_vs) begin
            miscompares++; fb = first_bad20(out_vector_s, exp_vs);
            $display("FAIL sat_vec20 job %0d row %0d got %0d want %0d", j, fb, $signed(out_vector_s[fb*AWS +: AWS]), $signed(exp_vs[fb*AWS +: AWS]));
         end
         vectors++; if (out_sat_s !== exp_sat_s) begin miscompares++; $display("FAIL sat_flag20 job %0d got %b want %b", j, out_sat_s, exp_sat_s); end
         vectors++;
         if (out_vector !== exp_v) begin
            miscompares++; fb = first_bad32(out_vector, exp_v);
            $display("FAIL sat_vec32 job %0d row %0d got %0d want %0d", j, fb, $signed(out_vector[fb*AW +: AW]), $signed(exp_v[fb*AW +: AW]));
         end
         vectors++; if (out_sat !== exp_sat) begin miscompares++; $display("FAIL sat_flag32 job %0d got %b want %b", j, out_sat, exp_sat); end
         @(negedge clk);
      end
   endtask

   task automatic test_back_to_back;
      int fb, nraw, nb, total, start;
      logic sg;
      total = 0;
      start = cyc;
      for (int j = 0; j < 12; j++) begin
         nraw = (j == 0) ? 0 : (j == 1) ? 31 : $urandom_range(0, 20);
         nb = eff_tiles(nraw);
         sg = 1'($urandom_range(0, 1));
         fill_random(nb);
         model_job(nb, sg);
         run_job(nb, TW'(nraw), sg);
         total += nb;
         vectors++; if (out_valid !== 1'b1 || busy !== 1'b0) begin miscompares++; $display("FAIL b2b_valid job %0d got valid %b busy %b want 1 0", j, out_valid, busy); end
         vectors++;
         if (out_vector !== exp_v) begin
            miscompares++; fb = first_bad32(out_vector, exp_v);
            $display("FAIL b2b_vec job %0d row %0d got %0d want %0d", j, fb, $signed(out_vector[fb*AW +: AW]), $signed(exp_v[fb*AW +: AW]));
         end
         vectors++;
         if (out_vector_s !== exp_vs || out_sat_s !== exp_sat_s || out_sat !== exp_sat) begin
            miscompares++; fb = first_bad20(out_vector_s, exp_vs);
            $display("FAIL b2b_vec20 job %0d row %0d got %0d sat %b want %0d sat %b", j, fb, $signed(out_vector_s[fb*AWS +: AWS]), out_sat_s, $signed(exp_vs[fb*AWS +: AWS]), exp_sat_s);
         end
      end
      vectors++; if (cyc - start != total) begin miscompares++; $display("FAIL b2b_cycles got %0d want %0d", cyc - start, total); end
      in_valid = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_backpressure;
      int fb;
      out_ready = 1'b0;
      fill_random(2);
      model_job(2, 1'b1);
      run_job(2, TW'(2), 1'b1);
      hold_v = exp_v;
      vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL bp_first_valid got %b want 1", out_valid); end
      fill_random(1);
      model_job(1, 1'b0);
      cfg_num_tiles = TW'(1);
      cfg_signed = 1'b0;
      for (int c = 0; c < COLS; c++) in_vector[c*IW +: IW] = x_arr[0][c];
      for (int r = 0; r < ROWS; r++)
         for (int c = 0; c < COLS; c++) in_weights[(r*COLS + c)*WW +: WW] = w_arr[0][r][c];
      in_valid = 1'b1;
      #1;
      for (int k = 0; k < 10; k++) begin
         vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL bp_in_ready cycle %0d got %b want 0", k, in_ready); end
         vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL bp_hold_valid cycle %0d got %b want 1", k, out_valid); end
         vectors++;
         if (out_vector !== hold_v) begin
            miscompares++; fb = first_bad32(out_vector, hold_v);
            $display("FAIL bp_hold_vec cycle %0d row %0d got %0d want %0d", k, fb, $signed(out_vector[fb*AW +: AW]), $signed(hold_v[fb*AW +: AW]));
         end
         @(negedge clk);
         #1;
      end
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL bp_swap_valid got %b want 1", out_valid); end
      vectors++;
      if (out_vector !== exp_v) begin
         miscompares++; fb = first_bad32(out_vector, exp_v);
         $display("FAIL bp_swap_vec row %0d got %0d want %0d", fb, $signed(out_vector[fb*AW +: AW]), $signed(exp_v[fb*AW +: AW]));
      end
      @(negedge clk);
      vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL bp_drain_valid got %b want 0", out_valid); end
   endtask

   task automatic test_abort;
      int fb;
      logic sg;
      // Clear a pending saturated result.
      out_ready = 1'b0;
      fill_const(4, 8'h80, 8'h80);
      run_job(4, TW'(4), 1'b1);
      in_valid = 1'b0;
      sw_clear = 1'b1;
      #1;
      vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL abort_in_ready got %b want 1", in_ready); end
      @(posedge clk);
      @(negedge clk);
      sw_clear = 1'b0;
      out_ready = 1'b1;
      vectors++; if (out_valid_s !== 1'b0 || out_sat_s !== 1'b0) begin miscompares++; $display("FAIL abort_slot got valid %b sat %b want 0 0", out_valid_s, out_sat_s); end
      // Abort mid-job with a beat on the bus.
      fill_random(4);
      run_job(2, TW'(4), 1'b1);
      vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL abort_busy_before got %b want 1", busy); end
      sw_clear = 1'b1;
      send_beat(2, TW'(4), 1'b1);
      sw_clear = 1'b0;
      in_valid = 1'b0;
      vectors++; if (busy !== 1'b0 || out_valid !== 1'b0) begin miscompares++; $display("FAIL abort_state got busy %b valid %b want 0 0", busy, out_valid); end
      sg = 1'($urandom_range(0, 1));
      fill_random(1);
      model_job(1, sg);
      run_job(1, TW'(1), sg);
      in_valid = 1'b0;
      vectors++;
      if (out_valid !== 1'b1 || out_vector !== exp_v) begin
         miscompares++; fb = first_bad32(out_vector, exp_v);
         $display("FAIL abort_next_vec valid %b row %0d got %0d want %0d", out_valid, fb, $signed(out_vector[fb*AW +: AW]), $signed(exp_v[fb*AW +: AW]));
      end
      @(negedge clk);
   endtask

   task automatic test_async_reset;
      int fb;
      out_ready = 1'b0;
      fill_random(1);
      run_job(1, TW'(1), 1'b1);
      in_valid = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      vectors++; if (out_valid !== 1'b0 || out_sat !== 1'b0 || busy !== 1'b0) begin miscompares++; $display("FAIL areset_pending got valid %b sat %b busy %b want 0 0 0", out_valid, out_sat, busy); end
      vectors++; if (out_vector !== '0 || out_vector_s !== '0) begin miscompares++; $display("FAIL areset_pending_vec got nonzero want 0"); end
      vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL areset_in_ready got %b want 1", in_ready); end
      @(negedge clk);
      rst_n = 1'b1;
      out_ready = 1'b1;
      @(negedge clk);
      fill_random(4);
      run_job(2, TW'(4), 1'b0);
      in_valid = 1'b0;
      vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL areset_midjob_busy_before got %b want 1", busy); end
      #2 rst_n = 1'b0;
      #1;
      vectors++; if (busy !== 1'b0 || out_valid !== 1'b0) begin miscompares++; $display("FAIL areset_midjob got busy %b valid %b want 0 0", busy, out_valid); end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      fill_random(3);
      model_job(3, 1'b1);
      run_job(3, TW'(3), 1'b1);
      in_valid = 1'b0;
      vectors++;
      if (out_valid !== 1'b1 || out_vector !== exp_v) begin
         miscompares++; fb = first_bad32(out_vector, exp_v);
         $display("FAIL areset_next_vec valid %b row %0d got %0d want %0d", out_valid, fb, $signed(out_vector[fb*AW +: AW]), $signed(exp_v[fb*AW +: AW]));
      end
      vectors++; if (out_sat_s !== exp_sat_s) begin miscompares++; $display("FAIL areset_next_sat20 got %b want %b", out_sat_s, exp_sat_s); end
      @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_single_signed();
      test_four_unsigned();
      test_saturation();
      test_back_to_back();
      test_backpressure();
      test_abort();
      test_async_reset();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
